// File: rtl/timer_bank.sv
`default_nettype none
// ============================================================================
// Module   : timer_bank
// Brief    : NUM_TIMERS countdown timers (16-bit or dual 8-bit) with shared
//            prescalers, compare/underflow interrupts and a byte-wide bus.
// Revision : 1.0 - initial release
// ============================================================================
module timer_bank #(
  parameter int          NUM_TIMERS = 3,
  parameter logic [23:0] BASE_ADDR  = 24'h2030,
  parameter int          STRIDE     = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rt_tick,
  input  logic                    bus_write,
  input  logic                    bus_read,
  input  logic [23:0]             bus_address_in,
  input  logic [7:0]              bus_data_in,
  output logic [7:0]              bus_data_out,
  output logic [2*NUM_TIMERS-1:0] irqs
);

  logic [12:0] r_p1;
  logic [7:0]  r_p2;
  logic [7:0]  w_rd_ch [NUM_TIMERS];
  logic        w_unused;

  // Reads have no side effects, so the strobe is not needed for decode.
  assign w_unused = bus_read ^ r_p1[12];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_p1 <= '0;
      r_p2 <= '0;
    end else begin
      r_p1 <= r_p1 + 13'd1;
      if (rt_tick) r_p2 <= r_p2 + 8'd1;
    end
  end

  function automatic logic f_tick(input logic osc, input logic [2:0] pre,
                                  input logic [12:0] p1, input logic [7:0] p2,
                                  input logic rt);
    logic [12:0] m1;
    logic [7:0]  m2;
    case (pre)
      3'd0:    m1 = 13'h0001;
      3'd1:    m1 = 13'h0007;
      3'd2:    m1 = 13'h001f;
      3'd3:    m1 = 13'h003f;
      3'd4:    m1 = 13'h007f;
      3'd5:    m1 = 13'h00ff;
      3'd6:    m1 = 13'h03ff;
      default: m1 = 13'h0fff;
    endcase
    m2 = 8'((9'd1 << pre) - 9'd1);
    return osc ? (rt && ((p2 & m2) == m2)) : ((p1 & m1) == m1);
  endfunction

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
    localparam logic [23:0] c_base = BASE_ADDR + 24'(STRIDE * i);

    logic [7:0]  r_ctrl_l, r_ctrl_h;
    logic [15:0] r_preset, r_compare, r_count;
    logic [1:0]  r_irq;

    logic [23:0] w_off;
    logic        w_hit, w_wr_ctrl_l, w_wr_ctrl_h;
    logic        w_rel_l, w_rel_h, w_rel_mode16;
    logic        w_tick_l, w_tick_h;
    logic [15:0] w_count_nx;
    logic [1:0]  w_irq_nx;
    logic [7:0]  w_rd;

    assign w_off        = bus_address_in - c_base;
    assign w_hit        = (w_off < 24'd8);
    assign w_wr_ctrl_l  = bus_write && w_hit && (w_off[2:0] == 3'd0);
    assign w_wr_ctrl_h  = bus_write && w_hit && (w_off[2:0] == 3'd1);
    assign w_rel_l      = w_wr_ctrl_l && bus_data_in[1];
    assign w_rel_h      = w_wr_ctrl_h && bus_data_in[1];
    // A reload_l write carries the new mode16, which decides its width.
    assign w_rel_mode16 = bus_data_in[7];
    assign w_tick_l     = r_ctrl_l[2] && f_tick(r_ctrl_l[0], r_ctrl_l[6:4], r_p1, r_p2, rt_tick);
    assign w_tick_h     = r_ctrl_h[2] && f_tick(r_ctrl_h[0], r_ctrl_h[6:4], r_p1, r_p2, rt_tick);

    always_comb begin
      w_count_nx = r_count;
      w_irq_nx   = 2'b00;
      if (w_rel_l && w_rel_mode16) begin
        w_count_nx = r_preset;
      end else if (r_ctrl_l[7]) begin
        if (w_rel_l) begin
          w_count_nx[7:0] = r_preset[7:0];
        end else if (w_tick_l) begin
          if (r_count == 16'd0) begin
            w_count_nx  = r_preset;
            w_irq_nx[1] = 1'b1;
          end else begin
            w_count_nx = r_count - 16'd1;
          end
          if (w_count_nx == r_compare) w_irq_nx[0] = 1'b1;
        end
      end else begin
        // Independent halves: each reloads on its own zero byte.
        if (w_rel_l) begin
          w_count_nx[7:0] = r_preset[7:0];
        end else if (w_tick_l) begin
          if (r_count[7:0] == 8'd0) begin
            w_count_nx[7:0] = r_preset[7:0];
            w_irq_nx[0]     = 1'b1;
          end else begin
            w_count_nx[7:0] = r_count[7:0] - 8'd1;
          end
        end
        if (w_rel_h) begin
          w_count_nx[15:8] = r_preset[15:8];
        end else if (w_tick_h) begin
          if (r_count[15:8] == 8'd0) begin
            w_count_nx[15:8] = r_preset[15:8];
            w_irq_nx[1]      = 1'b1;
          end else begin
            w_count_nx[15:8] = r_count[15:8] - 8'd1;
          end
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_ctrl_l  <= '0;
        r_ctrl_h  <= '0;
        r_preset  <= '0;
        r_compare <= '0;
        r_count   <= '0;
        r_irq     <= '0;
      end else begin
        r_count <= w_count_nx;
        r_irq   <= w_irq_nx;
        if (bus_write && w_hit) begin
          case (w_off[2:0])
            3'd0:    r_ctrl_l        <= bus_data_in & 8'hf5;
            3'd1:    r_ctrl_h        <= bus_data_in & 8'h75;
            3'd2:    r_preset[7:0]   <= bus_data_in;
            3'd3:    r_preset[15:8]  <= bus_data_in;
            3'd4:    r_compare[7:0]  <= bus_data_in;
            3'd5:    r_compare[15:8] <= bus_data_in;
            default: ;
          endcase
        end
      end
    end

    always_comb begin
      w_rd = 8'h00;
      if (w_hit) begin
        case (w_off[2:0])
          3'd0: w_rd = r_ctrl_l;
          3'd1: w_rd = r_ctrl_h;
          3'd2: w_rd = r_preset[7:0];
          3'd3: w_rd = r_preset[15:8];
          3'd4: w_rd = r_compare[7:0];
          3'd5: w_rd = r_compare[15:8];
          3'd6: w_rd = r_count[7:0];
          3'd7: w_rd = r_count[15:8];
        endcase
      end
    end

    assign w_rd_ch[i]     = w_rd;
    assign irqs[2*i +: 2] = r_irq;
  end

  always_comb begin
    bus_data_out = 8'h00;
    for (int j = 0; j < NUM_TIMERS; j++) bus_data_out = bus_data_out | w_rd_ch[j];
  end

endmodule
`default_nettype wire

// File: tb/tb_timer_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_bank
// Brief    : Directed self-checking bench for timer_bank (3 channels).
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_bank;
  localparam int N = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rt_tick = 1'b0;
  logic          bus_write = 1'b0;
  logic          bus_read = 1'b0;
  logic [23:0]   bus_address_in = '0;
  logic [7:0]    bus_data_in = '0;
  logic [7:0]    bus_data_out;
  logic [2*N-1:0] irqs;

  int total = 0;
  int passed = 0;
  int failed = 0;

  timer_bank #(.NUM_TIMERS(N), .BASE_ADDR(24'h2030), .STRIDE(8)) dut (
    .clk(clk), .reset(reset), .rt_tick(rt_tick),
    .bus_write(bus_write), .bus_read(bus_read),
    .bus_address_in(bus_address_in), .bus_data_in(bus_data_in),
    .bus_data_out(bus_data_out), .irqs(irqs)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [23:0] a, input logic [7:0] d);
    bus_address_in = a;
    bus_data_in    = d;
    bus_write      = 1'b1;
    step();
    bus_write      = 1'b0;
  endtask

  task automatic rd(input logic [23:0] a, output logic [7:0] d);
    bus_address_in = a;
    bus_read       = 1'b1;
    #1;
    d        = bus_data_out;
    bus_read = 1'b0;
  endtask

  task automatic rd16(input logic [23:0] a, output logic [15:0] v);
    logic [7:0] h, l;
    rd(a + 24'd7, h);
    rd(a + 24'd6, l);
    v = {h, l};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    logic [7:0]  d;
    int          n;
    logic        irq_seen;

    // reset state
    #2;
    check("rst_irqs", 32'(irqs), 32'h0);
    rd(24'h2030, d);    check("rst_ctrl0", 32'(d), 32'h00);
    rd16(24'h2040, v);  check("rst_count2", 32'(v), 32'h0000);
    step(); step();
    reset = 1'b1;

    // 16-bit mode on ch1: preset 3, compare 1, clk/2
    wr(24'h203A, 8'h03); wr(24'h203B, 8'h00);
    wr(24'h203C, 8'h01); wr(24'h203D, 8'h00);
    wr(24'h2038, 8'h82);
    rd16(24'h2038, v);  check("u16_reload", 32'(v), 32'h0003);
    rd(24'h2038, d);    check("u16_rel_rd0", 32'(d), 32'h80);
    wr(24'h2038, 8'h84);
    n = 0;
    rd16(24'h2038, v);
    while (v == 16'h0003 && n < 10) begin step(); rd16(24'h2038, v); n++; end
    check("u16_cnt2", 32'(v), 32'h0002);
    check("u16_irq_a", 32'(irqs), 32'h00);
    step();
    rd16(24'h2038, v);  check("u16_hold2", 32'(v), 32'h0002);
    step();
    rd16(24'h2038, v);  check("u16_cnt1", 32'(v), 32'h0001);
    check("u16_cmp_irq", 32'(irqs), 32'h04);
    step();
    check("u16_cmp_1cyc", 32'(irqs), 32'h00);
    step();
    rd16(24'h2038, v);  check("u16_cnt0", 32'(v), 32'h0000);
    check("u16_irq_b", 32'(irqs), 32'h00);
    step(); step();
    rd16(24'h2038, v);  check("u16_wrap3", 32'(v), 32'h0003);
    check("u16_unf_irq", 32'(irqs), 32'h08);
    wr(24'h2038, 8'h80);
    step(); step();
    rd16(24'h2038, v);  check("u16_stopped", 32'(v), 32'h0003);

    // 8-bit mode on ch0: preset 0x0502
    wr(24'h2032, 8'h02); wr(24'h2033, 8'h05);
    wr(24'h2031, 8'h02); wr(24'h2030, 8'h02);
    rd16(24'h2030, v);  check("u8_reload", 32'(v), 32'h0502);
    wr(24'h2031, 8'h04);
    n = 0;
    rd16(24'h2030, v);
    while (v[15:8] == 8'h05 && n < 10) begin step(); rd16(24'h2030, v); n++; end
    check("u8_hi_first", 32'(v), 32'h0402);
    wr(24'h2030, 8'h04);
    step();
    rd16(24'h2030, v);  check("u8_t1", 32'(v), 32'h0301);
    check("u8_t1_irq", 32'(irqs), 32'h00);
    step(); step();
    rd16(24'h2030, v);  check("u8_t2", 32'(v), 32'h0200);
    check("u8_t2_irq", 32'(irqs), 32'h00);
    step(); step();
    rd16(24'h2030, v);  check("u8_t3", 32'(v), 32'h0102);
    check("u8_t3_irq", 32'(irqs), 32'h01);
    step(); step();
    rd16(24'h2030, v);  check("u8_t4", 32'(v), 32'h0001);
    check("u8_t4_irq", 32'(irqs), 32'h00);
    step(); step();
    rd16(24'h2030, v);  check("u8_t5", 32'(v), 32'h0500);
    check("u8_t5_irq", 32'(irqs), 32'h02);
    step(); step();
    rd16(24'h2030, v);  check("u8_t6", 32'(v), 32'h0402);
    check("u8_t6_irq", 32'(irqs), 32'h01);
    wr(24'h2030, 8'h00);
    wr(24'h2031, 8'h00);
    rd16(24'h2030, v);  check("u8_disabled", 32'(v), 32'h0302);

    // count bytes are read-only
    wr(24'h2036, 8'hAA); wr(24'h2037, 8'hBB);
    step();
    rd16(24'h2030, v);  check("cnt_ro", 32'(v), 32'h0302);

    // oscillator 2 on ch2: pre 3 -> one step per 8 rt_ticks
    wr(24'h2042, 8'h10); wr(24'h2043, 8'h00);
    wr(24'h2040, 8'hB3); wr(24'h2040, 8'hB5);
    repeat (100) step();
    rd16(24'h2040, v);  check("osc2_idle", 32'(v), 32'h0010);
    for (int k = 1; k <= 16; k++) begin
      repeat (9) step();
      rt_tick = 1'b1;
      step();
      rt_tick = 1'b0;
      if (k == 7) begin rd16(24'h2040, v); check("osc2_7", 32'(v), 32'h0010); end
      if (k == 8) begin rd16(24'h2040, v); check("osc2_8", 32'(v), 32'h000F); end
    end
    rd16(24'h2040, v);  check("osc2_16", 32'(v), 32'h000E);

    // reload strobe beats a simultaneous underflow tick
    wr(24'h2040, 8'h80);
    wr(24'h2042, 8'h01);
    wr(24'h2040, 8'h82);
    rd16(24'h2040, v);  check("pri_cnt1", 32'(v), 32'h0001);
    wr(24'h2040, 8'h85);
    rt_tick = 1'b1;
    step();
    rt_tick = 1'b0;
    rd16(24'h2040, v);  check("pri_cnt0", 32'(v), 32'h0000);
    check("pri_cmp0_irq", 32'(irqs), 32'h10);
    wr(24'h2042, 8'h77);
    check("pri_irq_clr", 32'(irqs), 32'h00);
    rt_tick = 1'b1;
    wr(24'h2040, 8'h87);
    rt_tick = 1'b0;
    rd16(24'h2040, v);  check("pri_reload", 32'(v), 32'h0077);
    check("pri_no_irq", 32'(irqs), 32'h00);

    // bus decode of ch2 and unmapped neighbours
    rd(24'h2040, d);    check("dec_ctrl_l", 32'(d), 32'h85);
    rd(24'h2041, d);    check("dec_ctrl_h", 32'(d), 32'h00);
    rd(24'h2042, d);    check("dec_pre_lo", 32'(d), 32'h77);
    rd(24'h2043, d);    check("dec_pre_hi", 32'(d), 32'h00);
    rd(24'h2044, d);    check("dec_cmp_lo", 32'(d), 32'h00);
    rd(24'h2046, d);    check("dec_cnt_lo", 32'(d), 32'h77);
    rd(24'h2048, d);    check("dec_unmapped_hi", 32'(d), 32'h00);
    rd(24'h202F, d);    check("dec_unmapped_lo", 32'(d), 32'h00);
    rd(24'h203A, d);    check("dec_ch1_pre", 32'(d), 32'h03);

    // asynchronous reset mid-count
    wr(24'h2038, 8'h84);
    step(); step(); step();
    #2;
    reset = 1'b0;
    #1;
    check("arst_irqs", 32'(irqs), 32'h00);
    rd16(24'h2038, v);  check("arst_cnt1", 32'(v), 32'h0000);
    rd(24'h2038, d);    check("arst_ctrl1", 32'(d), 32'h00);
    rd(24'h2042, d);    check("arst_pre2", 32'(d), 32'h00);
    reset = 1'b1;
    irq_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (irqs != '0) irq_seen = 1'b1;
    end
    check("post_rst_irqs", 32'(irq_seen), 32'h0);
    rd16(24'h2038, v);  check("post_rst_cnt", 32'(v), 32'h0000);
    rd(24'h2038, d);    check("post_rst_ctrl", 32'(d), 32'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
